// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, and the select/operation codes driven onto the datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// ALU operation decode from funct3/funct7/op[5]; the same mapping is used
// by the single-cycle core.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (funct3_i)
      // op[5] separates R-type from immediate forms: there is no subi
      3'b000:  alu_control_o = (op5_i & funct7_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control_o = ALU_SLT;
      3'b110:  alu_control_o = ALU_OR;
      3'b111:  alu_control_o = ALU_AND;
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, stalling on memory, and counts retirements.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7_i,
  input  logic             Zero_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             AdrSrc_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       ResultSrc_o,
  output logic [1:0]       ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALUControl_o,
  output logic [2:0]       ImmSrc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o,
  output state_t           state_dbg_o
);

  state_t     state;
  state_t     state_next;
  logic       retire;
  logic       jal_wb;
  logic [2:0] exec_alu;

  alu_op_decode u_alu_op_decode (
    .funct3_i      (funct3_i),
    .funct7_i      (funct7_i),
    .op5_i         (op_i[5]),
    .alu_control_o (exec_alu)
  );

  assign state_dbg_o = state;

  // Memory handshake: MemRead_o/MemWrite_o act as valid and stay high until
  // the cycle mem_ready_i is seen; that cycle completes the access and the
  // FSM moves on. mem_ready_i is ignored in every other state.
  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    PCWrite_o    = 1'b0;
    AdrSrc_o     = 1'b0;
    MemRead_o    = 1'b0;
    MemWrite_o   = 1'b0;
    IRWrite_o    = 1'b0;
    RegWrite_o   = 1'b0;
    ResultSrc_o  = RES_ALUOUT;
    ALUSrcA_o    = SRCA_PC;
    ALUSrcB_o    = SRCB_RD2;
    ALUControl_o = ALU_ADD;
    ImmSrc_o     = IMM_I;
    illegal_o    = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead_o   = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        if (mem_ready_i) begin
          IRWrite_o  = 1'b1;
          PCWrite_o  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm: the branch or jump target
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = (op_i == OP_JAL) ? IMM_J : IMM_B;
        case (op_i)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default: begin
            illegal_o  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o  = SRCA_RD1;
        ALUSrcB_o  = SRCB_IMM;
        ImmSrc_o   = op_i[5] ? IMM_S : IMM_I;
        state_next = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc_o  = 1'b1;
        MemRead_o = 1'b1;
        if (mem_ready_i) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = RES_DATA;
        RegWrite_o  = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        MemWrite_o = 1'b1;
        if (mem_ready_i) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA_o    = SRCA_RD1;
        ALUSrcB_o    = (state == S_EXEC_I) ? SRCB_IMM : SRCB_RD2;
        ALUControl_o = exec_alu;
        state_next   = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite_o = 1'b1;
        // a JAL already retired in its own state
        retire     = ~jal_wb;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o    = SRCA_RD1;
        ALUControl_o = ALU_SUB;
        PCWrite_o    = funct3_i[0] ? ~Zero_i : Zero_i;
        retire       = 1'b1;
        state_next   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA_o  = SRCA_OLDPC;
        ALUSrcB_o  = SRCB_FOUR;
        PCWrite_o  = 1'b1;
        retire     = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    if (rst_i) begin
      PCWrite_o    = 1'b0;
      AdrSrc_o     = 1'b0;
      MemRead_o    = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      RegWrite_o   = 1'b0;
      ResultSrc_o  = 2'b00;
      ALUSrcA_o    = 2'b00;
      ALUSrcB_o    = 2'b00;
      ALUControl_o = 3'b000;
      ImmSrc_o     = 3'b000;
      illegal_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      jal_wb    <= 1'b0;
      instret_o <= '0;
    end else begin
      state  <= state_next;
      jal_wb <= (state == S_JAL);
      if (retire) instret_o <= instret_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: an instruction-level model
// expands each instruction into its expected per-cycle control words.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int W     = 19;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rgw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [2:0] imm;
    logic       ill;
  } ctrl_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  logic [6:0]       op_i;
  logic [2:0]       funct3_i;
  logic             funct7_i;
  logic             Zero_i;
  logic             mem_ready_i;
  logic             PCWrite_o, AdrSrc_o, MemRead_o, MemWrite_o;
  logic             IRWrite_o, RegWrite_o, illegal_o;
  logic [1:0]       ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
  logic [2:0]       ALUControl_o, ImmSrc_o;
  logic [CNT_W-1:0] instret_o;
  state_t           state_dbg;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .Zero_i       (Zero_i),
    .mem_ready_i  (mem_ready_i),
    .PCWrite_o    (PCWrite_o),
    .AdrSrc_o     (AdrSrc_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .IRWrite_o    (IRWrite_o),
    .RegWrite_o   (RegWrite_o),
    .ResultSrc_o  (ResultSrc_o),
    .ALUSrcA_o    (ALUSrcA_o),
    .ALUSrcB_o    (ALUSrcB_o),
    .ALUControl_o (ALUControl_o),
    .ImmSrc_o     (ImmSrc_o),
    .illegal_o    (illegal_o),
    .instret_o    (instret_o),
    .state_dbg_o  (state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           model_cnt = 0;
  logic [6:0]   cur_op = '0;
  logic [2:0]   cur_f3 = '0;
  logic         cur_f7 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive inputs at negedge, compare just after, edge follows
  task automatic cyc(input ctrl_t e, input bit rdy, input bit z, input bit rst,
                     input bit retire, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(negedge clk);
    rst_i       = rst;
    mem_ready_i = rdy;
    Zero_i      = z;
    op_i        = cur_op;
    funct3_i    = cur_f3;
    funct7_i    = cur_f7;
    exp_q.push_back(e);
    #1;
    got = {PCWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o,
           ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, illegal_o};
    exp = exp_q.pop_front();
    check(tag, 32'(got), 32'(exp));
    check({tag, "_cnt"}, 32'(instret_o), 32'(model_cnt % (1 << CNT_W)));
    if (rst) model_cnt = 0;
    else if (retire) model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic ctrl_t fetch_c(input bit rdy);
    ctrl_t c = '0;
    c.mrd  = 1'b1;
    c.srcb = 2'b10;
    c.res  = 2'b10;
    c.pcw  = rdy;
    c.irw  = rdy;
    return c;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [2:0] f3, input bit subtract);
    case (f3)
      3'b000:  return subtract ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected cycle sequence of one instruction; abort resets during the
  // store wait instead of completing it.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fetch_wait, input int mem_wait, input bit z,
                           input bit abort);
    ctrl_t c;
    bit    legal;
    cur_op = o;
    cur_f3 = f3;
    cur_f7 = f7;
    for (int i = 0; i < fetch_wait; i++) cyc(fetch_c(1'b0), 1'b0, rb(), 1'b0, 1'b0, "fetch_wait");
    cyc(fetch_c(1'b1), 1'b1, rb(), 1'b0, 1'b0, "fetch");

    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    c = '0;
    c.srca = 2'b01;
    c.srcb = 2'b01;
    c.imm  = (o == 7'b1101111) ? 3'b011 : 3'b001;
    c.ill  = !legal;
    cyc(c, rb(), rb(), 1'b0, 1'b0, "decode");
    if (!legal) return;

    if (o == 7'b0000011 || o == 7'b0100011) begin
      c = '0;
      c.srca = 2'b10;
      c.srcb = 2'b01;
      c.imm  = o[5] ? 3'b010 : 3'b000;
      cyc(c, rb(), rb(), 1'b0, 1'b0, "memadr");
      c = '0;
      c.adr = 1'b1;
      if (o[5]) begin
        c.mwr = 1'b1;
        for (int i = 0; i < mem_wait; i++) cyc(c, 1'b0, rb(), 1'b0, 1'b0, "mw_wait");
        if (abort) begin
          cyc(ctrl_t'('0), 1'b1, rb(), 1'b1, 1'b0, "mw_reset");
          return;
        end
        cyc(c, 1'b1, rb(), 1'b0, 1'b1, "mw_done");
      end else begin
        c.mrd = 1'b1;
        for (int i = 0; i < mem_wait; i++) cyc(c, 1'b0, rb(), 1'b0, 1'b0, "mr_wait");
        cyc(c, 1'b1, rb(), 1'b0, 1'b0, "mr_done");
        c = '0;
        c.res = 2'b01;
        c.rgw = 1'b1;
        cyc(c, rb(), rb(), 1'b0, 1'b1, "memwb");
      end
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      c = '0;
      c.srca = 2'b10;
      c.srcb = o[5] ? 2'b00 : 2'b01;
      c.aluc = exp_alu(f3, o[5] & f7);
      cyc(c, rb(), rb(), 1'b0, 1'b0, "exec");
      c = '0;
      c.rgw = 1'b1;
      cyc(c, rb(), rb(), 1'b0, 1'b1, "aluwb");
    end else if (o == 7'b1100011) begin
      c = '0;
      c.srca = 2'b10;
      c.aluc = 3'b001;
      c.pcw  = f3[0] ? !z : z;
      cyc(c, rb(), z, 1'b0, 1'b1, "branch");
    end else begin
      c = '0;
      c.srca = 2'b01;
      c.srcb = 2'b10;
      c.pcw  = 1'b1;
      cyc(c, rb(), rb(), 1'b0, 1'b1, "jal");
      c = '0;
      c.rgw = 1'b1;
      cyc(c, rb(), rb(), 1'b0, 1'b0, "jal_wb");
    end
  endtask

  // stimulus
  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    int         r;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

    rst_i = 1'b1; mem_ready_i = 1'b0; Zero_i = 1'b0;
    op_i = '0; funct3_i = '0; funct7_i = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) cyc(ctrl_t'('0), rb(), rb(), 1'b1, 1'b0, "reset");

    // reset release with memory not ready, then R-type sub
    run_instr(7'b0110011, 3'b000, 1'b1, 3, 0, 1'b0, 1'b0);
    // load with three wait cycles in MEMREAD
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0, 1'b0);
    // BNE then BEQ with both Zero values
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1, 1'b0);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1, 0, 1'b0, 1'b0);
    // reset while a store waits on memory
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 2, 1'b0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) o = ops[r];
      else if (r == 6) o = 7'($urandom_range(0, 127));
      else o = ops[$urandom_range(2, 4)];
      run_instr(o, 3'($urandom_range(0, 7)), rb(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3), rb(),
                ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It replaces single-cycle decode with a registered state machine that drives a shared-ALU / unified-memory datapath. Each instruction is walked through fetch, decode, execute, memory and writeback, and the block stalls on memory through a ready handshake. It also keeps a retired-instruction counter for bring-up and performance checks.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret_o.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, synchronous, active-high.
op_i  in  7  opcode field from the instruction register.
funct3_i  in  3  funct3 field from the instruction register.
funct7_i  in  1  instr[30].
Zero_i  in  1  ALU zero flag (combinational, current cycle).
mem_ready_i  in  1  memory has completed the current access this cycle.
PCWrite_o  out  1  PC register load enable.
AdrSrc_o  out  1  memory address select: 0 = PC, 1 = Result.
MemRead_o  out  1  read request, held until mem_ready_i.
MemWrite_o  out  1  write request, held until mem_ready_i.
IRWrite_o  out  1  instruction register and OldPC load enable.
RegWrite_o  out  1  register file write enable.
ResultSrc_o  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA_o  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rd1.
ALUSrcB_o  out  2  ALU B select: 00 = rd2, 01 = imm, 10 = constant 4.
ALUControl_o  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
ImmSrc_o  out  3  immediate type: 000 I, 001 B, 010 S, 011 J.
illegal_o  out  1  one-cycle pulse on an unsupported opcode.
instret_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: one clock and a synchronous, active-high reset (clk_i, rst_i).
  - With rst_i high at a clock edge: state <= FETCH and instret_o <= 0.
  - While rst_i is high, every strobe output (PCWrite, MemRead, MemWrite, IRWrite, RegWrite, illegal) is forced to 0 and every mux select is 0.
  - Reset mid-access abandons the access; there is no pending-transaction memory.
- Outputs are Moore (decoded from state), except for three Mealy terms:
  - PCWrite_o and IRWrite_o are gated by mem_ready_i in FETCH.
  - The branch PCWrite_o depends on Zero_i.
- Unlisted outputs in every state are 0.

FETCH:
- Drives AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
- If mem_ready_i: IRWrite=1, PCWrite=1 (PC+4), next state DECODE.
- Otherwise stay in FETCH with no PC or IR write.

DECODE:
- Drives ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add; this forms the branch target into ALUOut.
- Next state by op_i:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> FETCH, with illegal_o=1 for this cycle.

MEMADR:
- Drives ALUSrcA=10, ALUSrcB=01, add.
- ImmSrc=S if op_i[5]=1, else I.
- Next state MEMWRITE if op_i[5]=1, else MEMREAD.

MEMREAD:
- Drives AdrSrc=1, ResultSrc=00, MemRead=1.
- Stays in MEMREAD until mem_ready_i, then goes to MEMWB.

MEMWB:
- Drives ResultSrc=01, RegWrite=1.
- Next state FETCH; instret_o increments.

MEMWRITE:
- Drives AdrSrc=1, ResultSrc=00, MemWrite=1.
- Holds until mem_ready_i, then goes to FETCH; instret_o increments on the ready cycle.

EXEC_R / EXEC_I:
- Drive ALUSrcA=10, with ALUSrcB=00 (EXEC_R) or 01 with ImmSrc=I (EXEC_I).
- ALUControl by funct3:
  - 000: sub if op_i[5] & funct7_i, else add
  - 010: slt
  - 110: or
  - 111: and
  - other funct3 values: add.
- Next state ALUWB.

ALUWB:
- Drives ResultSrc=00, RegWrite=1.
- Next state FETCH; instret_o increments.

BRANCH:
- Drives ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
- PCWrite = funct3_i[0] ? ~Zero_i : Zero_i.
- Next state FETCH; instret_o increments.

JAL:
- Drives ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
- The PC takes ALUOut, which holds the J target computed in DECODE with ImmSrc=J.
- DECODE uses ImmSrc=J when op_i=1101111, otherwise B.
- Next state ALUWB; that writeback does not increment the counter again, so instret_o increments here, exactly once per JAL.

Other rules:
- instret_o wraps modulo 2^CNT_W.
- mem_ready_i outside FETCH, MEMREAD and MEMWRITE is ignored.
- MemRead_o and MemWrite_o are never asserted in the same cycle.

Decomposition:
- Package ctrl_pkg holds:
  - enum state_t;
  - localparams for opcodes, ALU codes, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module, alu_op_decode: combinational mapping of funct3_i, funct7_i and op_i[5] to ALUControl, shared with the single-cycle core.

Test Plan:
- Reset held 3 cycles, then released with mem_ready_i=0 -> state FETCH, MemRead_o=1, PCWrite_o=0, instret_o=0 until ready.
- R-type sub (op 0110011, funct3 000, funct7 1) with mem_ready_i=1 -> FETCH, DECODE, EXEC_R (ALUControl=001), ALUWB (RegWrite=1); instret_o=1 after 4 cycles.
- Load with mem_ready_i delayed 3 cycles in MEMREAD -> MemRead_o held 4 cycles, AdrSrc_o=1, then MEMWB with ResultSrc=01 and RegWrite=1; instruction takes 8 cycles total.
- BNE (funct3 001): Zero_i=0 -> PCWrite_o=1 in BRANCH; repeat with Zero_i=1 -> PCWrite_o=0; BEQ gives the inverse results.
- Opcode 1111111 -> illegal_o pulses once in DECODE, return to FETCH, instret_o unchanged.
- rst_i asserted during MEMWRITE wait -> MemWrite_o=0 that cycle, FETCH on the next cycle, instret_o=0.
